heap_sort_seq_ctrl: RTL and testbench

//  Clocked, resource-shared replacement for the combinational heap sorter in the trigger

---
 rtl/heap_sort_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_heap_sort_seq_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/heap_sort_seq_ctrl.sv
// Sequential in-place heap sorter: collects a batch over valid/ready, heapifies and sorts it
// with one sift step per cycle (two comparators, one swap), then streams the result out.
module heap_sort_seq_ctrl #(
    parameter int ARRAY_SIZE   = 32,
    parameter int ELEMENT_SIZE = 32,
    parameter bit DESCENDING   = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [ELEMENT_SIZE-1:0]           in_data,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ELEMENT_SIZE-1:0]           out_data,
    output logic                              out_last,
    output logic                              busy,
    output logic [$clog2(ARRAY_SIZE+1)-1:0]   batch_len
);

    localparam int AW = $clog2(ARRAY_SIZE);
    localparam int IW = AW + 1;
    localparam int CW = $clog2(ARRAY_SIZE + 1);

    typedef enum logic [2:0] {
        LOAD,
        BUILD,
        SORT_SWAP,
        SORT_SIFT,
        DRAIN
    } state_t;

    state_t                  state_q;
    logic [CW-1:0]           count_q;
    logic [CW-1:0]           batch_len_q;
    logic [IW-1:0]           n_q;
    logic [IW-1:0]           m_q;
    logic [IW-1:0]           i_q;
    logic [IW-1:0]           k_q;
    logic [IW-1:0]           j_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    out_last_q;
    logic                    busy_q;
    logic [ELEMENT_SIZE-1:0] out_data_q;

    logic [ELEMENT_SIZE-1:0] mem [ARRAY_SIZE];

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign batch_len = batch_len_q;

    function automatic logic better(input logic [ELEMENT_SIZE-1:0] a,
                                    input logic [ELEMENT_SIZE-1:0] b);
        return DESCENDING ? (a < b) : (a > b);
    endfunction

    // Sift step datapath: children are one bit wider than n so 2n+2 cannot wrap.
    logic [IW:0]             l_idx;
    logic [IW:0]             r_idx;
    logic                    l_ok;
    logic                    r_ok;
    logic [ELEMENT_SIZE-1:0] v_n;
    logic [ELEMENT_SIZE-1:0] v_l;
    logic [ELEMENT_SIZE-1:0] v_r;
    logic [ELEMENT_SIZE-1:0] v_best;
    logic [IW-1:0]           best_idx;
    logic                    sift_swap;

    always_comb begin
        l_idx    = {n_q, 1'b0} + (IW+1)'(1);
        r_idx    = {n_q, 1'b0} + (IW+1)'(2);
        l_ok     = l_idx < {1'b0, m_q};
        r_ok     = r_idx < {1'b0, m_q};
        v_n      = mem[n_q[AW-1:0]];
        v_l      = l_ok ? mem[l_idx[AW-1:0]] : '0;
        v_r      = r_ok ? mem[r_idx[AW-1:0]] : '0;
        best_idx = n_q;
        v_best   = v_n;
        if (l_ok && better(v_l, v_best)) begin
            best_idx = l_idx[IW-1:0];
            v_best   = v_l;
        end
        if (r_ok && better(v_r, v_best)) begin
            best_idx = r_idx[IW-1:0];
            v_best   = v_r;
        end
        sift_swap = (best_idx != n_q);
    end

    logic                    handshake_in;
    logic                    handshake_out;
    logic [CW-1:0]           len_next;
    logic [IW-1:0]           half_m1;
    logic [IW-1:0]           j_next;
    logic [IW-1:0]           last_idx;

    always_comb begin
        handshake_in  = in_valid && in_ready_q;
        handshake_out = out_valid_q && out_ready;
        len_next      = count_q + CW'(1);
        half_m1       = (IW'(len_next) >> 1) - IW'(1);
        j_next        = j_q + IW'(1);
        last_idx      = IW'(batch_len_q) - IW'(1);
    end

    // Two write ports: load uses one, a swap uses both.
    logic                    we0;
    logic                    we1;
    logic [AW-1:0]           wa0;
    logic [AW-1:0]           wa1;
    logic [ELEMENT_SIZE-1:0] wd0;
    logic [ELEMENT_SIZE-1:0] wd1;

    always_comb begin
        we0 = 1'b0;
        we1 = 1'b0;
        wa0 = '0;
        wa1 = '0;
        wd0 = '0;
        wd1 = '0;
        case (state_q)
            LOAD: begin
                if (handshake_in) begin
                    we0 = 1'b1;
                    wa0 = count_q[AW-1:0];
                    wd0 = in_data;
                end
            end
            BUILD, SORT_SIFT: begin
                if (sift_swap) begin
                    we0 = 1'b1;
                    we1 = 1'b1;
                    wa0 = n_q[AW-1:0];
                    wd0 = v_best;
                    wa1 = best_idx[AW-1:0];
                    wd1 = v_n;
                end
            end
            SORT_SWAP: begin
                we0 = 1'b1;
                we1 = 1'b1;
                wa0 = '0;
                wd0 = mem[k_q[AW-1:0]];
                wa1 = k_q[AW-1:0];
                wd1 = mem[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we0) mem[wa0] <= wd0;
        if (we1) mem[wa1] <= wd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            count_q     <= '0;
            batch_len_q <= '0;
            n_q         <= '0;
            m_q         <= '0;
            i_q         <= '0;
            k_q         <= '0;
            j_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (handshake_in) begin
                        count_q <= len_next;
                        if (in_last || count_q == CW'(ARRAY_SIZE - 1)) begin
                            batch_len_q <= len_next;
                            in_ready_q  <= 1'b0;
                            busy_q      <= 1'b1;
                            if (count_q == '0) begin
                                // Single element: mem[0] is being written now, forward it.
                                state_q     <= DRAIN;
                                out_valid_q <= 1'b1;
                                out_data_q  <= in_data;
                                out_last_q  <= 1'b1;
                                j_q         <= '0;
                            end else begin
                                state_q <= BUILD;
                                m_q     <= IW'(len_next);
                                i_q     <= half_m1;
                                n_q     <= half_m1;
                            end
                        end
                    end
                end
                BUILD: begin
                    if (sift_swap) begin
                        n_q <= best_idx;
                    end else if (i_q == '0) begin
                        state_q <= SORT_SWAP;
                        k_q     <= m_q - IW'(1);
                    end else begin
                        i_q <= i_q - IW'(1);
                        n_q <= i_q - IW'(1);
                    end
                end
                SORT_SWAP: begin
                    state_q <= SORT_SIFT;
                    n_q     <= '0;
                    m_q     <= k_q;
                end
                SORT_SIFT: begin
                    if (sift_swap) begin
                        n_q <= best_idx;
                    end else if (k_q == IW'(1)) begin
                        state_q     <= DRAIN;
                        out_valid_q <= 1'b1;
                        out_data_q  <= mem[0];
                        out_last_q  <= 1'b0;
                        j_q         <= '0;
                    end else begin
                        k_q     <= k_q - IW'(1);
                        state_q <= SORT_SWAP;
                    end
                end
                DRAIN: begin
                    if (handshake_out) begin
                        if (out_last_q) begin
                            state_q     <= LOAD;
                            count_q     <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            in_ready_q  <= 1'b1;
                        end else begin
                            j_q        <= j_next;
                            out_data_q <= mem[j_next[AW-1:0]];
                            out_last_q <= (j_next == last_idx);
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_heap_sort_seq_ctrl.sv
// Directed bench for heap_sort_seq_ctrl: an ascending and a descending instance, each with
// a scoreboard queue of expected sorted words filled at load time and drained by a monitor.
module tb_heap_sort_seq_ctrl;

    localparam int N  = 32;
    localparam int W  = 32;
    localparam int LW = $clog2(N + 1);

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          a_in_valid = 1'b0;
    logic          a_in_ready;
    logic [W-1:0]  a_in_data = '0;
    logic          a_in_last = 1'b0;
    logic          a_out_valid;
    logic          a_out_ready = 1'b1;
    logic [W-1:0]  a_out_data;
    logic          a_out_last;
    logic          a_busy;
    logic [LW-1:0] a_batch_len;

    logic          d_in_valid = 1'b0;
    logic          d_in_ready;
    logic [W-1:0]  d_in_data = '0;
    logic          d_in_last = 1'b0;
    logic          d_out_valid;
    logic          d_out_ready = 1'b1;
    logic [W-1:0]  d_out_data;
    logic          d_out_last;
    logic          d_busy;
    logic [LW-1:0] d_batch_len;

    exp_t          qa[$];
    exp_t          qd[$];
    exp_t          ea;
    exp_t          ed;
    logic [W-1:0]  batch[$];
    logic [W-1:0]  w33;
    logic [W-1:0]  w34;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    heap_sort_seq_ctrl #(.ARRAY_SIZE(N), .ELEMENT_SIZE(W), .DESCENDING(1'b0)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .busy(a_busy), .batch_len(a_batch_len)
    );

    heap_sort_seq_ctrl #(.ARRAY_SIZE(N), .ELEMENT_SIZE(W), .DESCENDING(1'b1)) dut_d (
        .clk(clk), .rst(rst),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data), .in_last(d_in_last),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
        .out_last(d_out_last), .busy(d_busy), .batch_len(d_batch_len)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference sort of the current batch into the selected scoreboard.
    task automatic push_expected(input bit sel);
        logic [W-1:0] s[$];
        logic [W-1:0] t;
        exp_t         e;
        s = batch;
        for (int i = 1; i < s.size(); i++) begin
            for (int j = i; j > 0; j--) begin
                if (sel ? (s[j] > s[j-1]) : (s[j] < s[j-1])) begin
                    t = s[j]; s[j] = s[j-1]; s[j-1] = t;
                end
            end
        end
        for (int i = 0; i < s.size(); i++) begin
            e.data = s[i];
            e.last = (i == s.size() - 1);
            if (sel) qd.push_back(e);
            else     qa.push_back(e);
        end
    endtask

    task automatic send(input bit sel, input logic [W-1:0] v, input logic last);
        int   cyc;
        logic rdy;
        cyc = 0;
        if (sel) begin d_in_valid = 1'b1; d_in_data = v; d_in_last = last; end
        else     begin a_in_valid = 1'b1; a_in_data = v; a_in_last = last; end
        @(negedge clk);
        rdy = sel ? d_in_ready : a_in_ready;
        while (!rdy && cyc < 2000) begin
            @(negedge clk);
            rdy = sel ? d_in_ready : a_in_ready;
            cyc++;
        end
        chk("in_ready_wait", rdy, 1);
        @(posedge clk);
        #1;
        if (sel) begin d_in_valid = 1'b0; d_in_last = 1'b0; end
        else     begin a_in_valid = 1'b0; a_in_last = 1'b0; end
    endtask

    task automatic send_batch(input bit sel, input bit with_last);
        for (int i = 0; i < batch.size(); i++)
            send(sel, batch[i], with_last && (i == batch.size() - 1));
    endtask

    task automatic wait_drain(input bit sel, input bit rnd);
        int cyc;
        cyc = 0;
        while (((sel ? qd.size() : qa.size()) != 0) && cyc < 3000) begin
            @(posedge clk);
            #1;
            if (rnd) begin
                if (sel) d_out_ready = 1'($urandom_range(0, 1));
                else     a_out_ready = 1'($urandom_range(0, 1));
            end
            cyc++;
        end
        a_out_ready = 1'b1;
        d_out_ready = 1'b1;
        chk(sel ? "d_drain_done" : "a_drain_done", sel ? qd.size() : qa.size(), 0);
        chk(sel ? "d_in_ready_after" : "a_in_ready_after", sel ? d_in_ready : a_in_ready, 1);
        chk(sel ? "d_busy_after" : "a_busy_after", sel ? d_busy : a_busy, 0);
        chk(sel ? "d_out_valid_after" : "a_out_valid_after", sel ? d_out_valid : a_out_valid, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            chk("a_pop_expected", qa.size() != 0, 1);
            if (qa.size() != 0) begin
                ea = qa.pop_front();
                chk("a_out_data", a_out_data, ea.data);
                chk("a_out_last", a_out_last, ea.last);
            end
        end
        if (!rst && d_out_valid && d_out_ready) begin
            chk("d_pop_expected", qd.size() != 0, 1);
            if (qd.size() != 0) begin
                ed = qd.pop_front();
                chk("d_out_data", d_out_data, ed.data);
                chk("d_out_last", d_out_last, ed.last);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_last", a_out_last, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_batch_len", a_batch_len, 0);
        chk("rst_out_data", a_out_data, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Small ascending batch
        batch = '{32'd7, 32'd3, 32'd9, 32'd1, 32'd5};
        push_expected(0);
        send_batch(0, 1);
        chk("t1_busy", a_busy, 1);
        chk("t1_in_ready_low", a_in_ready, 0);
        chk("t1_batch_len", a_batch_len, 5);
        wait_drain(0, 0);

        // Full batch in reverse order, then already sorted
        batch.delete();
        for (int i = 0; i < N; i++) batch.push_back(W'(N - 1 - i));
        push_expected(0);
        send_batch(0, 1);
        chk("t2_batch_len", a_batch_len, N);
        wait_drain(0, 0);
        batch.delete();
        for (int i = 0; i < N; i++) batch.push_back(W'(i));
        push_expected(0);
        send_batch(0, 1);
        wait_drain(0, 0);

        // Duplicates, both orders
        batch = '{32'd4, 32'd4, 32'd2, 32'd4, 32'd2, 32'd0};
        push_expected(0);
        send_batch(0, 1);
        wait_drain(0, 0);
        push_expected(1);
        send_batch(1, 1);
        chk("t3_d_batch_len", d_batch_len, 6);
        wait_drain(1, 0);

        // Single element goes straight to output
        batch = '{32'hDEADBEEF};
        push_expected(0);
        send_batch(0, 1);
        chk("t4_busy", a_busy, 1);
        chk("t4_out_valid", a_out_valid, 1);
        chk("t4_out_last", a_out_last, 1);
        chk("t4_batch_len", a_batch_len, 1);
        wait_drain(0, 0);

        // Overflow: 33rd word is held and starts the next batch
        batch.delete();
        for (int i = 0; i < N; i++) batch.push_back($urandom);
        push_expected(0);
        send_batch(0, 0);
        chk("t5_in_ready_held", a_in_ready, 0);
        chk("t5_batch_len", a_batch_len, N);
        w33 = $urandom;
        w34 = $urandom;
        batch = '{w33, w34};
        push_expected(0);
        send(0, w33, 1'b0);
        send(0, w34, 1'b1);
        chk("t5_next_len", a_batch_len, 2);
        wait_drain(0, 1);

        // Random backpressure on a full random batch
        batch.delete();
        for (int i = 0; i < N; i++) batch.push_back($urandom_range(0, 15));
        push_expected(0);
        send_batch(0, 1);
        wait_drain(0, 1);

        // Reset in the middle of sorting
        batch.delete();
        for (int i = 0; i < N; i++) batch.push_back(W'(N - 1 - i));
        send_batch(0, 1);
        repeat (40) @(posedge clk);
        #1;
        chk("t6_busy_pre_rst", a_busy, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_in_ready", a_in_ready, 1);
        chk("t6_rst_out_valid", a_out_valid, 0);
        chk("t6_rst_busy", a_busy, 0);
        chk("t6_rst_batch_len", a_batch_len, 0);
        chk("t6_rst_out_data", a_out_data, 0);
        chk("t6_rst_out_last", a_out_last, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        batch = '{32'd3, 32'd1, 32'd2};
        push_expected(0);
        send_batch(0, 1);
        wait_drain(0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
